sar_adc_ctrl: RTL and testbench
===============================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: conversion resolution in bits; legal range 4..12.
REQ-002 Parameter SAMPLE_CYCLES, default 2: cycles the track/hold switch is closed; legal range >=1.
REQ-003 Parameter SETTLE_CYCLES, default 4: cycles per bit trial; legal range >=3.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  conversion request; sampled each rising edge.
REQ-008 comp_in  in  1  analog comparator output, asynchronous; 1 = DAC voltage above held input.
REQ-009 sample_en  out  1  track/hold switch control; 1 = tracking.
REQ-010 dac_code  out  WIDTH  capacitive-DAC trial code driven to the analog array.
REQ-011 busy  out  1  high from the cycle after start is accepted until the result is loaded.
REQ-012 done  out  1  one-cycle pulse on the result-load cycle.
REQ-013 out_valid  out  1  result holding register is full.
REQ-014 out_ready  in  1  consumer accepts result when out_valid & out_ready.
REQ-015 result  out  WIDTH  converted code; stable while out_valid=1 and no new load occurs.
REQ-016 overrun  out  1  one-cycle pulse when an unconsumed result is overwritten.

Function
REQ-017 comp_in SHALL pass through a 2-flop synchronizer; only the synchronized value comp_s is used.
REQ-018 FSM states: IDLE, SAMPLE, TRIAL; no other states.
REQ-019 IDLE: sample_en=0, dac_code=0, busy=0; start=1 at an edge -> SAMPLE; start=0 -> stay in IDLE.
REQ-020 SAMPLE: sample_en=1, dac_code=0, busy=1 for exactly SAMPLE_CYCLES cycles, then TRIAL with bit index i=WIDTH-1.
REQ-021 TRIAL bit i: dac_code = the accumulated code with bit i forced to 1, held for exactly SETTLE_CYCLES cycles; sample_en=0.
REQ-022 On the last cycle of bit i, if comp_s=1, bit i SHALL be cleared in the accumulated code; otherwise it is kept. Lower bits stay 0 until tried.
REQ-023 After bit 0 is decided, the final code SHALL be loaded into result, out_valid set, done pulsed, and the FSM returns to IDLE on the same edge.
REQ-024 Latency: with start sampled at the end of cycle 0, busy=1 during cycles 1..SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES; the load happens at the end of the last of those cycles. out_valid, done and result are visible from cycle SAMPLE_CYCLES+WIDTH*SETTLE_CYCLES+1 (cycle 35 with defaults).
REQ-025 start while busy=1 SHALL be ignored, with no queuing.
REQ-026 start SHALL be accepted in IDLE regardless of out_valid; conversion and holding register are independent.
REQ-027 out_valid SHALL clear on an edge where out_valid & out_ready and no load occurs.
REQ-028 Load with out_valid=1 and out_ready=0: result is overwritten, out_valid stays 1, overrun pulses for one cycle.
REQ-029 Load with out_valid=1 and out_ready=1: the old result is consumed, new result loaded, out_valid stays 1, no overrun.
REQ-030 Per-bit and sample counters SHALL be no wider than needed; there is no wrap-around beyond the defined counts.

Reset
REQ-031 When rst=1 at an edge: state=IDLE, counters=0, synchronizer flops=0, sample_en=0, dac_code=0, busy=0, done=0, out_valid=0, result=0, overrun=0.
REQ-032 rst mid-conversion SHALL abort it with no result load, done or overrun; start is ignored while rst=1.

Verification
REQ-033 Ideal comparator model comp_in=(dac_code>VIN), VIN=0x5A, pulse start, out_ready=1 -> sample_en high cycles 1-2; done and out_valid at cycle 35; result=0x5A; dac_code trial sequence begins 0x80,0x40,0x60,0x50,0x58,0x5C.
REQ-034 VIN=0x00 gives result 0x00; VIN=0xFF gives result 0xFF; both at cycle 35.
REQ-035 Two back-to-back conversions, out_ready=0, VIN 0x11 then 0x22 -> second load gives overrun=1 for one cycle, result=0x22, out_valid=1.
REQ-036 start held high for 50 cycles -> exactly one conversion accepted during busy; a new one starts at the first IDLE edge.
REQ-037 rst=1 at cycle 10 of a conversion -> next cycle all outputs 0; no done, out_valid=0; a new start afterward converts normally.
REQ-038 out_ready toggling 1/0 each cycle while out_valid=1 -> out_valid clears on the first handshake edge; result is unchanged until then.

Source files
------------

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC sequencer: drives track/hold and the capacitive
// DAC, resolves one bit per settle window and holds the result for a consumer.
module sar_adc_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             comp_in,
  input  logic             out_ready,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overrun
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SAMPLE, TRIAL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   code_q, code_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               sync1_q, comp_s_q;
  logic               load;
  logic [WIDTH-1:0]   trial_bit;

  assign trial_bit = {{(WIDTH-1){1'b0}}, 1'b1} << bit_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      code_q    <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      sync1_q   <= 1'b0;
      comp_s_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      code_q    <= code_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
      sync1_q   <= comp_in;
      comp_s_q  <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    code_d    = code_q;
    load      = 1'b0;
    sample_en = 1'b0;
    dac_code  = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = SAMPLE;
      end
      SAMPLE: begin
        sample_en = 1'b1;
        busy      = 1'b1;
        if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d = TRIAL;
          cnt_d   = '0;
          bit_d   = BIT_W'(WIDTH - 1);
          code_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TRIAL: begin
        busy     = 1'b1;
        dac_code = code_q | trial_bit;
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          // DAC above the held input means the trial bit overshoots: drop it.
          if (!comp_s_q) code_d = code_q | trial_bit;
          if (bit_q == '0) begin
            load    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q - BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    result_d  = result_q;
    valid_d   = valid_q;
    done_d    = load;
    overrun_d = 1'b0;
    if (load) begin
      result_d  = code_d;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~out_ready;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  assign done      = done_q;
  assign out_valid = valid_q;
  assign result    = result_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Directed and randomized bench for sar_adc_ctrl with an ideal comparator and
// a cycle-level reference model of conversion timing and the holding register.
module tb_sar_adc_ctrl;

  localparam int WIDTH  = 8;
  localparam int SAMPLE = 2;
  localparam int SETTLE = 4;
  localparam int TOTAL  = SAMPLE + WIDTH * SETTLE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             comp_in;
  logic             out_ready = 1'b0;
  logic             sample_en;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic             done;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             overrun;
  logic [WIDTH-1:0] vin = '0;

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: cycles since the conversion was accepted (0 = idle).
  int               m_t = 0;
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic             m_done = 1'b0;
  logic             m_ovr = 1'b0;

  sar_adc_ctrl #(.WIDTH(WIDTH), .SAMPLE_CYCLES(SAMPLE), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .start(start), .comp_in(comp_in), .out_ready(out_ready),
    .sample_en(sample_en), .dac_code(dac_code), .busy(busy), .done(done),
    .out_valid(out_valid), .result(result), .overrun(overrun)
  );

  assign comp_in = (dac_code > vin);

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] exp_dac(input int t, input logic [WIDTH-1:0] v);
    int i;
    logic [WIDTH-1:0] upper;
    if (t <= SAMPLE) return '0;
    i = WIDTH - 1 - (t - SAMPLE - 1) / SETTLE;
    upper = v & ~((WIDTH'(1) << (i + 1)) - WIDTH'(1));
    if (i == WIDTH - 1) upper = '0;
    return upper | (WIDTH'(1) << i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, expv);
  endtask

  task automatic step();
    logic load;
    @(negedge clk);
    load = 1'b0;
    if (rst) begin
      m_t = 0; m_valid = 1'b0; m_result = '0; m_done = 1'b0; m_ovr = 1'b0;
    end else begin
      m_done = 1'b0;
      m_ovr  = 1'b0;
      if (m_t == 0) begin
        if (start) m_t = 1;
      end else if (m_t == TOTAL) begin
        load = 1'b1;
        m_t  = 0;
      end else begin
        m_t++;
      end
      if (load) begin
        m_ovr    = m_valid && !out_ready;
        m_valid  = 1'b1;
        m_result = vin;
        m_done   = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
    chk("sample_en", 32'(sample_en), 32'(m_t >= 1 && m_t <= SAMPLE));
    chk("dac_code",  32'(dac_code),  32'((m_t == 0) ? '0 : exp_dac(m_t, vin)));
    chk("busy",      32'(busy),      32'(m_t != 0));
    chk("done",      32'(done),      32'(m_done));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("result",    32'(result),    32'(m_result));
    chk("overrun",   32'(overrun),   32'(m_ovr));
    if (m_done) $display("conversion vin=%02h result=%02h overrun=%0b", vin, result, overrun);
  endtask

  task automatic convert(input logic [WIDTH-1:0] v, input int rdy_mode);
    vin   = v;
    start = 1'b1;
    for (int k = 0; k <= TOTAL + 2; k++) begin
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        2: out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      step();
      start = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    convert(8'h5A, 1);
    convert(8'h00, 1);
    convert(8'hFF, 1);
    for (int n = 0; n < 4; n++) convert(WIDTH'($urandom), 3);

    // Back-to-back with no consumer: second load must overrun.
    convert(8'h11, 0);
    convert(8'h22, 0);
    // Toggling ready drains the holding register on the first handshake.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      out_ready = ~out_ready;
      step();
    end

    // Start held high: one conversion at a time, re-accepted when idle.
    vin = WIDTH'($urandom);
    out_ready = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 50; k++) step();
    start = 1'b0;
    for (int k = 0; k < 30; k++) step();

    // Reset mid-conversion aborts cleanly, then a fresh conversion works.
    vin = 8'h3C;
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 9; k++) step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    for (int k = 0; k < 3; k++) step();
    convert(WIDTH'($urandom), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
